obj_dma_ctrl: RTL and testbench
===============================

# obj_dma_ctrl

Object-RAM DMA controller that sits directly downstream of the video timing generator. It decodes the generator's 9-bit vertical count into the sprite DMA window (lines 479–494) and drives the active-low DMA strobe. Within that window it requests the CPU bus and copies the CPU-side object RAM into the sprite engine's shadow object RAM, one word per two pixel-clock enables. It runs on the same master clock and 6 MHz pixel enable as the timing generator.

## Interface
Parameters:
- OBJ_WORDS, 2048: number of 16-bit words copied per frame; must satisfy 2*OBJ_WORDS + 4 ≤ 6144.
- AW, 11: address width; 2^AW ≥ OBJ_WORDS.

Ports:
- i_EMU_MCLK  in  1  master clock; the block has one clock.
- i_MRST_n  in  1  reset, asynchronous and active-low.
- i_EMU_CLK6MPCEN_n  in  1  pixel-clock enable, active-low; all state advances only on enabled edges.
- i_VCNT  in  9  vertical counter from the timing generator (248..511).
- o_DMA_n  out  1  DMA window strobe, low for i_VCNT 479..494.
- o_BUSRQ_n  out  1  CPU bus request, active-low.
- i_BUSAK_n  in  1  CPU bus acknowledge, active-low.
- o_SRC_ADDR  out  AW  CPU object-RAM read address.
- o_SRC_RD_n  out  1  CPU object-RAM read strobe.
- i_SRC_DATA  in  16  CPU object-RAM read data, valid while o_SRC_RD_n is low.
- o_DST_ADDR  out  AW  shadow object-RAM write address.
- o_DST_DATA  out  16  shadow write data.
- o_DST_WR_n  out  1  shadow write strobe.
- o_BUSY  out  1  high from request until bus release.
- o_OVR  out  1  sticky overrun flag: the copy did not complete inside the window.

## Operation
- Window decode: on each enable, o_DMA_n <= !(479 ≤ i_VCNT ≤ 494). A registered copy, dma_q, is kept for edge detection.
- Start event: o_DMA_n = 0 while dma_q = 1 (falling edge of the window). The start event clears o_OVR.
- States: IDLE, REQ, RD, WR, DONE.
  - IDLE: on a start event, go to REQ and assert o_BUSRQ_n = 0. The address counter n is set to 0.
  - REQ: if i_BUSAK_n = 0, go to RD. If the window has closed (o_DMA_n = 1), set o_OVR, raise o_BUSRQ_n and go to IDLE.
  - RD: o_SRC_ADDR = n and o_SRC_RD_n = 0. On the exiting enable, latch i_SRC_DATA into o_DST_DATA and go to WR.
  - WR: o_DST_ADDR = n and o_DST_WR_n = 0. On the exiting enable, the next state is chosen as follows:
    - if n == OBJ_WORDS-1, go to DONE;
    - else if o_DMA_n = 1, set o_OVR and go to DONE;
    - otherwise n <= n+1 and go to RD.
  - DONE: o_BUSRQ_n = 1, then go to IDLE on the next enable.
- Address counter n is AW bits wide. It never wraps, because it is bounded by OBJ_WORDS-1.
- If the bus is released (i_BUSAK_n goes high) during RD/WR, the current word still completes; grant loss is a CPU-side protocol error and is not detected.
- Aborts never cut a word in half. A transfer that has entered RD always completes its WR.

## Timing
- Reset values:
  - o_DMA_n = 1, dma_q = 1
  - o_BUSRQ_n = 1, o_SRC_RD_n = 1, o_DST_WR_n = 1
  - o_SRC_ADDR = 0, o_DST_ADDR = 0, o_DST_DATA = 0
  - o_BUSY = 0, o_OVR = 0
  - state = IDLE, n = 0
- Reset mid-transfer forces all strobes and the bus request inactive immediately (asynchronous).
- All strobes and addresses are registered and change only on enabled edges.
- o_DMA_n falls 1 enable after i_VCNT becomes 479. o_BUSRQ_n falls 1 enable after that.
- With acknowledge already low, the first RD begins 1 enable after o_BUSRQ_n falls. Each word then takes exactly 2 enables.
- The final WR is followed by 1 DONE enable; o_BUSRQ_n rises on the edge that leaves DONE.
- o_BUSY = (state != IDLE).
- A start event in any state other than IDLE is ignored. This cannot occur legally, since windows are one frame apart.

## Structure
- Shared package holds:
  - state enum {IDLE, REQ, RD, WR, DONE};
  - constants DMA_V_START = 9'd479 and DMA_V_END = 9'd494, shared with the timing generator's VBLANK constants.
- Sub-module obj_dma_window: window decode plus edge detect, producing o_DMA_n and a start pulse. Everything else stays flat.

## Test plan
- Normal copy, OBJ_WORDS = 16, acknowledge tied low, i_VCNT stepped 478→479:
  - BUSRQ_n falls 2 enables later;
  - 16 writes with o_DST_ADDR 0..15 matching source data;
  - BUSRQ_n high after 1+32+1 enables;
  - o_OVR = 0.
- Late grant: acknowledge delayed 10 enables → first RD 1 enable after the acknowledge falls; the copy completes.
- Grant never given, window closes at i_VCNT = 495 → BUSRQ_n returns high, o_OVR = 1, no writes occur.
- Window closes mid-copy (acknowledge held for all but 8 enables of the window, OBJ_WORDS = 2048) → the in-flight word completes, then DONE; o_OVR = 1. The next frame's start clears o_OVR.
- Asynchronous reset asserted during WR → o_DST_WR_n and o_BUSRQ_n go high without waiting for an enable; state IDLE, n = 0.
- Enable held inactive for 100 MCLK cycles during RD → all outputs frozen; operation resumes unchanged.

Source files
------------

// File: rtl/obj_dma_ctrl_pkg.sv
// Shared types and vertical-window constants for the object-RAM DMA controller.
// The window limits match the timing generator's VBLANK decode.
package obj_dma_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE} dma_state_t;

  localparam logic [8:0] DMA_V_START = 9'd479;
  localparam logic [8:0] DMA_V_END   = 9'd494;

  function automatic logic in_dma_window(input logic [8:0] vcnt);
    return (vcnt >= DMA_V_START) && (vcnt <= DMA_V_END);
  endfunction

endpackage

// File: rtl/obj_dma_window.sv
// Sprite DMA window decode: registered active-low strobe plus a one-enable
// start pulse on its falling edge.
module obj_dma_window
  import obj_dma_ctrl_pkg::*;
(
  input  logic       i_EMU_MCLK,
  input  logic       i_MRST_n,
  input  logic       i_EMU_CLK6MPCEN_n,
  input  logic [8:0] i_VCNT,
  output logic       o_DMA_n,
  output logic       o_start
);

  logic dma_q;

  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      o_DMA_n <= 1'b1;
      dma_q   <= 1'b1;
    end else if (!i_EMU_CLK6MPCEN_n) begin
      o_DMA_n <= !in_dma_window(i_VCNT);
      dma_q   <= o_DMA_n;
    end
  end

  // Held between enables, so the FSM sees it on exactly one enabled edge.
  assign o_start = !o_DMA_n && dma_q;

endmodule

// File: rtl/obj_dma_ctrl.sv
// Object-RAM DMA controller: during the sprite DMA window it requests the CPU bus
// and copies CPU object RAM into the shadow object RAM, one word per two enables.
module obj_dma_ctrl
  import obj_dma_ctrl_pkg::*;
#(
  parameter int OBJ_WORDS = 2048,
  parameter int AW        = 11
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_MRST_n,
  input  logic          i_EMU_CLK6MPCEN_n,
  input  logic [8:0]    i_VCNT,
  output logic          o_DMA_n,
  output logic          o_BUSRQ_n,
  input  logic          i_BUSAK_n,
  output logic [AW-1:0] o_SRC_ADDR,
  output logic          o_SRC_RD_n,
  input  logic [15:0]   i_SRC_DATA,
  output logic [AW-1:0] o_DST_ADDR,
  output logic [15:0]   o_DST_DATA,
  output logic          o_DST_WR_n,
  output logic          o_BUSY,
  output logic          o_OVR
);

  localparam logic [AW-1:0] LAST = AW'(OBJ_WORDS - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  dma_state_t    state, state_d;
  logic [AW-1:0] n, n_d, src_addr_d, dst_addr_d;
  logic [15:0]   dst_data_d;
  logic          busrq_d, rd_d, wr_d, ovr_d;
  logic          start;

  obj_dma_window u_window (
    .i_EMU_MCLK        (i_EMU_MCLK),
    .i_MRST_n          (i_MRST_n),
    .i_EMU_CLK6MPCEN_n (i_EMU_CLK6MPCEN_n),
    .i_VCNT            (i_VCNT),
    .o_DMA_n           (o_DMA_n),
    .o_start           (start)
  );

  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state      <= IDLE;
      n          <= '0;
      o_BUSRQ_n  <= 1'b1;
      o_SRC_RD_n <= 1'b1;
      o_DST_WR_n <= 1'b1;
      o_SRC_ADDR <= '0;
      o_DST_ADDR <= '0;
      o_DST_DATA <= '0;
      o_OVR      <= 1'b0;
    end else if (!i_EMU_CLK6MPCEN_n) begin
      state      <= state_d;
      n          <= n_d;
      o_BUSRQ_n  <= busrq_d;
      o_SRC_RD_n <= rd_d;
      o_DST_WR_n <= wr_d;
      o_SRC_ADDR <= src_addr_d;
      o_DST_ADDR <= dst_addr_d;
      o_DST_DATA <= dst_data_d;
      o_OVR      <= ovr_d;
    end
  end

  // Strobes are one-enable pulses; everything else holds unless a state assigns it.
  always_comb begin
    state_d    = state;
    n_d        = n;
    busrq_d    = o_BUSRQ_n;
    rd_d       = 1'b1;
    wr_d       = 1'b1;
    src_addr_d = o_SRC_ADDR;
    dst_addr_d = o_DST_ADDR;
    dst_data_d = o_DST_DATA;
    ovr_d      = o_OVR;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          busrq_d = 1'b0;
          n_d     = '0;
          ovr_d   = 1'b0;
        end
      end
      REQ: begin
        if (!i_BUSAK_n) begin
          state_d    = RD;
          rd_d       = 1'b0;
          src_addr_d = n;
        end else if (o_DMA_n) begin
          state_d = IDLE;
          busrq_d = 1'b1;
          ovr_d   = 1'b1;
        end
      end
      RD: begin
        state_d    = WR;
        dst_data_d = i_SRC_DATA;
        wr_d       = 1'b0;
        dst_addr_d = n;
      end
      WR: begin
        // A started word always finishes; the window is only checked between words.
        if (n == LAST) begin
          state_d = DONE;
        end else if (o_DMA_n) begin
          state_d = DONE;
          ovr_d   = 1'b1;
        end else begin
          state_d    = RD;
          n_d        = n + ONE;
          rd_d       = 1'b0;
          src_addr_d = n + ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busrq_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_BUSY = (state != IDLE);

endmodule

// File: tb/tb_obj_dma_ctrl.sv
// Scoreboard bench for obj_dma_ctrl: randomized frames checked against an
// enable-indexed timeline model derived from the window and copy rules.
module tb_obj_dma_ctrl;

  localparam int OBJ = 16;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pcen_n = 1'b1;
  logic          ack_n = 1'b1;
  logic [8:0]    vcnt = 9'd470;
  logic          dma_n, busrq_n, rd_n, wr_n, busy, ovr;
  logic [AW-1:0] src_addr, dst_addr;
  logic [15:0]   src_data, dst_data;
  logic [15:0]   src_mem [OBJ];
  logic [29:0]   outs;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t w_exp;
  int  n_cmp = 0;
  int  n_err = 0;
  int  eidx = 0;
  bit  ovr_prev = 1'b0;

  always #5 clk = ~clk;

  assign src_data = rd_n ? 16'h0000 : src_mem[src_addr];
  assign outs = {dma_n, busrq_n, rd_n, wr_n, busy, ovr, src_addr, dst_addr, dst_data};

  obj_dma_ctrl #(.OBJ_WORDS(OBJ), .AW(AW)) dut (
    .i_EMU_MCLK        (clk),
    .i_MRST_n          (rst_n),
    .i_EMU_CLK6MPCEN_n (pcen_n),
    .i_VCNT            (vcnt),
    .o_DMA_n           (dma_n),
    .o_BUSRQ_n         (busrq_n),
    .i_BUSAK_n         (ack_n),
    .o_SRC_ADDR        (src_addr),
    .o_SRC_RD_n        (rd_n),
    .i_SRC_DATA        (src_data),
    .o_DST_ADDR        (dst_addr),
    .o_DST_DATA        (dst_data),
    .o_DST_WR_n        (wr_n),
    .o_BUSY            (busy),
    .o_OVR             (ovr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // A write lands on the next enabled edge while the write strobe is low.
  always @(negedge clk) begin
    if (rst_n && !pcen_n && !wr_n) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write t=%0t: addr %0h data %0h with no write expected",
                 $time, dst_addr, dst_data);
      end else begin
        w_exp = exp_q.pop_front();
        chk("wr_addr", 32'(dst_addr), 32'(w_exp.addr));
        chk("wr_data", 32'(dst_data), 32'(w_exp.data));
      end
    end
  end

  // One enabled clock edge, preceded by some disabled ones.
  task automatic en_edge(input int idle);
    pcen_n = 1'b1;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    pcen_n = 1'b0;
    @(posedge clk);
    #1;
    pcen_n = 1'b1;
  endtask

  // K enables per line, VCNT 470..505. Grant first sampled low D+1 enables after the
  // request edge (never, if never is set). Edge indices: window open for edges t0..t0+16K-1.
  task automatic run_frame(input int K, input int D, input bit never, input bit freeze,
                           input bit rst_wr);
    int e0, t0, S, C, A, R, nw;
    bit abort, ovr_exp, ovr_e, rd_e, wr_e;
    logic [8:0] v;
    logic [29:0] snap;
    for (int i = 0; i < OBJ; i++) src_mem[i] = 16'($urandom);
    e0 = eidx;
    t0 = e0 + 9 * K;
    S  = t0 + 1;
    C  = t0 + 16 * K + 1;
    A  = never ? 32'h3fff_ffff : S + 1 + D;
    if (A == C) A = C - 1;
    abort   = (A > C);
    ovr_exp = abort;
    nw      = 0;
    R       = C;
    if (!abort) begin
      forever begin
        nw++;
        if (nw == OBJ) break;
        if (A + 2 * nw >= C) begin
          ovr_exp = 1'b1;
          break;
        end
      end
      R = A + 2 * nw + 1;
      for (int i = 0; i < nw; i++) exp_q.push_back({AW'(i), src_mem[i]});
    end

    for (int x = e0; x < e0 + 36 * K; x++) begin
      v = 9'(470 + (x - e0) / K);
      vcnt  = v;
      ack_n = !(x >= A);
      en_edge(int'($urandom_range(0, 2)));
      eidx++;
      rd_e = !abort && x >= A && x < A + 2 * nw && ((x - A) % 2 == 0);
      wr_e = !abort && x > A && x < A + 2 * nw && ((x - A) % 2 == 1);
      if (x < S) ovr_e = ovr_prev;
      else if (abort) ovr_e = (x >= C);
      else ovr_e = ovr_exp && (x >= A + 2 * nw);
      chk("dma_n", 32'(dma_n), 32'(!(v >= 9'd479 && v <= 9'd494)));
      chk("busrq_n", 32'(busrq_n), 32'(!(x >= S && x < R)));
      chk("busy", 32'(busy), 32'(x >= S && x < R));
      chk("src_rd_n", 32'(rd_n), 32'(!rd_e));
      chk("dst_wr_n", 32'(wr_n), 32'(!wr_e));
      chk("ovr", 32'(ovr), 32'(ovr_e));
      if (rd_e) chk("src_addr", 32'(src_addr), (x - A) / 2);
      if (wr_e) chk("dst_addr", 32'(dst_addr), (x - A) / 2);
      if (freeze && x == A) begin
        snap = outs;
        repeat (100) begin
          @(posedge clk);
          #1;
        end
        chk("freeze_outputs", 32'(outs), 32'(snap));
      end
      if (rst_wr && x == A + 1) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dst_wr_n", 32'(wr_n), 32'd1);
        chk("rst_busrq_n", 32'(busrq_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_src_addr", 32'(src_addr), 32'd0);
        chk("rst_dst_addr", 32'(dst_addr), 32'd0);
        chk("rst_n_count", 32'(dut.n), 32'd0);
        chk("rst_dma_n", 32'(dma_n), 32'd1);
        exp_q.delete();
        ack_n = 1'b1;
        return;
      end
    end
    ack_n    = 1'b1;
    ovr_prev = ovr_exp;
    chk("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int K, D;
    bit nv;
    for (int i = 0; i < OBJ; i++) src_mem[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outs), 32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0}));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_outputs", 32'(outs), 32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0}));

    run_frame(3, 0, 1'b0, 1'b0, 1'b0);   // full copy with grant immediately
    run_frame(3, 10, 1'b0, 1'b0, 1'b0);  // late grant
    run_frame(2, 0, 1'b1, 1'b0, 1'b0);   // grant never given
    run_frame(1, 0, 1'b0, 1'b0, 1'b0);   // window closes mid-copy
    run_frame(3, 0, 1'b0, 1'b1, 1'b0);   // overrun cleared, enable frozen in RD
    for (int i = 0; i < 20; i++) begin
      K  = int'($urandom_range(1, 4));
      D  = int'($urandom_range(0, 24));
      nv = ($urandom_range(0, 4) == 0);
      run_frame(K, D, nv, 1'b0, 1'b0);
    end
    run_frame(2, 0, 1'b0, 1'b0, 1'b1);   // asynchronous reset during WR

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
